multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multi-cycle sequencer for the RISC-V core: replaces per-instruction combinational decode with a state machine that steps one shared memory port and the ALU/register-file datapath through FETCH, DECODE, EXEC, MEM and WB. It drives the same strobe set as the core's decode (`alu_op`, `pc_src`, `reg_wr`, `alu_src`, `mem_reg`, `mem_wr`, `mem_rd`), plus instruction-register, PC-write and address-select controls. It waits on a memory ready handshake, times out stalled accesses, and traps on illegal opcodes.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles a memory strobe may stay unanswered before a bus error. Legal range is 1..255.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `instruction` input 32: IR contents from the datapath; `[6:0]` is the opcode (`opcode_t`).
- `zero` input 1: ALU zero flag; sampled in EXEC for BEQ.
- `mem_ready` input 1: memory completed the current read/write this cycle.
- `alu_op` output 2: to ALU control.
- `pc_src` output `pc_src_t`: PC mux select (`PC_4`/`PC_B`/`PC_J`).
- `pc_wr` output 1: PC load enable.
- `ir_wr` output 1: IR and old-PC load enable.
- `iord` output 1: memory address select; 0 = PC, 1 = ALU result.
- `reg_wr`, `alu_src`, `mem_reg`, `mem_wr`, `mem_rd` output 1 each: datapath strobes.
- `instr_done` output 1: one-cycle pulse on the final cycle of each retired instruction.
- `illegal` output 1: sticky; an undefined opcode was decoded.
- `bus_err` output 1: sticky; a memory access timed out.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. The opcode is taken from `instruction` in DECODE and later states; the IR is stable after FETCH.
- Default for every strobe is 0, with `pc_src`=`PC_4` and `alu_op`=00. Only deviations from the default are listed below.
- FETCH
  - Drives `mem_rd`=1, `iord`=0.
  - On `mem_ready`: `ir_wr`=1, `pc_wr`=1 (`PC_4`), then go to DECODE. Otherwise stay.
- DECODE
  - One cycle.
  - Opcode in {R_Type, I_Type, LW, SW, BEQ, J}: go to EXEC.
  - Any other opcode: go to TRAP and set `illegal`.
- EXEC
  - R_Type: `alu_op`=10, `alu_src`=0; go to WB.
  - I_Type: `alu_op`=11, `alu_src`=1; go to WB.
  - LW/SW: `alu_op`=00, `alu_src`=1; go to MEM.
  - BEQ: `alu_op`=01, `alu_src`=0, `pc_src`=`PC_B`, `pc_wr`=`zero`; go to FETCH.
  - J: `pc_src`=`PC_J`, `pc_wr`=1; go to FETCH. No link write.
- MEM
  - `iord`=1, `alu_src`=1.
  - LW drives `mem_rd`=1; SW drives `mem_wr`=1.
  - On `mem_ready`: LW goes to WB, SW goes to FETCH.
- WB
  - `reg_wr`=1 for exactly one cycle; `mem_reg`=1 for LW, 0 otherwise.
  - Go to FETCH.
- TRAP
  - All strobes 0. Stays in TRAP until reset.
- Wait counter (8-bit)
  - Cleared on every state transition.
  - Increments each cycle in FETCH/MEM while `mem_ready`=0.
  - When it equals `MEM_TIMEOUT` with `mem_ready` still 0: go to TRAP, set `bus_err`, drop strobes next cycle.
  - `mem_ready` arriving on the same cycle as the limit wins: the access completes and there is no error.
- `instr_done`=1 on the cycle whose next state is FETCH: WB, BEQ/J EXEC, and SW MEM with `mem_ready`.
- `mem_ready` is ignored outside FETCH/MEM.

## Timing
- Strobes are combinational from state, opcode, `zero` and `mem_ready`. State, counter and sticky flags are registered.
- While waiting in FETCH/MEM, the strobe, `iord` and `alu_op` are held constant every cycle.
- Reset
  - Sampled on the clock edge while `rst`=0: state→FETCH, counter→0, `illegal`=`bus_err`=0.
  - While `rst`=0, all outputs are forced to defaults: 0, `PC_4`, `alu_op` 00.
  - Reset mid-instruction abandons it with no partial write after the reset edge.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the request cycle):
  - R/I: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/J: 3.
- Each wait cycle adds 1 to these counts.
- First FETCH strobe is asserted in the first cycle after `rst` rises.

## Test plan
- Reset, `mem_ready` tied 1, IR=R_Type `add`: FETCH→DECODE→EXEC(`alu_op`=10)→WB(`reg_wr`=1, `mem_reg`=0). `instr_done` is high in cycle 4 only.
- LW with `mem_ready` low for 3 MEM cycles: `mem_rd`/`iord`=1 held for 4 MEM cycles, then WB with `mem_reg`=1. `instr_done` asserts 8 cycles after FETCH start.
- BEQ with `zero`=1, then with `zero`=0: EXEC drives `pc_src`=`PC_B` in both cases, `pc_wr`=1 then 0. 3 cycles each, `reg_wr` never asserted.
- `MEM_TIMEOUT`=4, SW with `mem_ready` held 0: `mem_wr` high for 5 cycles, then TRAP, `bus_err`=1, all strobes 0. Repeat with `mem_ready` on exactly the 5th cycle: no error, return to FETCH.
- IR opcode 0x7F: after DECODE, `illegal`=1, FSM stays in TRAP for 20 cycles with no strobes. Asserting `rst`=0 for one cycle clears `illegal` and restarts FETCH.
- `rst`=0 asserted during LW WB: `reg_wr` is 0 in the reset cycle, all outputs are default, FETCH resumes after release.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Strobes are combinational from state/opcode/zero/mem_ready; state, wait counter and sticky flags are registered.
package multicycle_control_fsm_pkg;
  typedef enum logic [6:0] {
    LW     = 7'h03,
    I_Type = 7'h13,
    SW     = 7'h23,
    R_Type = 7'h33,
    BEQ    = 7'h63,
    J      = 7'h6F
  } opcode_t;

  typedef enum logic [1:0] {
    PC_4 = 2'd0,
    PC_B = 2'd1,
    PC_J = 2'd2
  } pc_src_t;
endpackage

module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  alu_op,
  output pc_src_t     pc_src,
  output logic        pc_wr,
  output logic        ir_wr,
  output logic        iord,
  output logic        reg_wr,
  output logic        alu_src,
  output logic        mem_reg,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic        instr_done,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;

  opcode_t op;
  logic    timed_out;
  logic    unused_instr_bits;

  assign op                = opcode_t'(instruction[6:0]);
  assign unused_instr_bits = ^instruction[31:7];
  assign timed_out         = (wait_q == TIMEOUT) && !mem_ready;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    alu_op     = 2'b00;
    pc_src     = PC_4;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    iord       = 1'b0;
    reg_wr     = 1'b0;
    alu_src    = 1'b0;
    mem_reg    = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = DECODE;
        end else if (timed_out) begin
          state_d   = TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        case (op)
          R_Type, I_Type, LW, SW, BEQ, J: state_d = EXEC;
          default: begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      EXEC: begin
        case (op)
          R_Type: begin
            alu_op  = 2'b10;
            state_d = WB;
          end
          I_Type: begin
            alu_op  = 2'b11;
            alu_src = 1'b1;
            state_d = WB;
          end
          LW, SW: begin
            alu_src = 1'b1;
            state_d = MEM;
          end
          BEQ: begin
            alu_op     = 2'b01;
            pc_src     = PC_B;
            pc_wr      = zero;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
          J: begin
            pc_src     = PC_J;
            pc_wr      = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
          default: begin
            // IR changed under us; treat like a decode failure rather than guess.
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEM: begin
        iord    = 1'b1;
        alu_src = 1'b1;
        mem_rd  = (op == LW);
        mem_wr  = (op != LW);
        if (mem_ready) begin
          instr_done = (op != LW);
          state_d    = (op == LW) ? WB : FETCH;
        end else if (timed_out) begin
          state_d   = TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB: begin
        reg_wr     = 1'b1;
        mem_reg    = (op == LW);
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      TRAP: ;
      default: state_d = FETCH;
    endcase

    if (state_d != state_q) wait_d = 8'd0;

    // Reset held low masks every output so nothing partial escapes the abandoned instruction.
    if (!rst) begin
      alu_op     = 2'b00;
      pc_src     = PC_4;
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      iord       = 1'b0;
      reg_wr     = 1'b0;
      alu_src    = 1'b0;
      mem_reg    = 1'b0;
      mem_wr     = 1'b0;
      mem_rd     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign illegal = rst & illegal_q;
  assign bus_err = rst & bus_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: an instruction-level model builds the expected
// per-cycle strobe trace from opcode, zero and memory wait counts, and checks cycles per instruction.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  alu_op;
  pc_src_t     pc_src;
  logic        pc_wr, ir_wr, iord, reg_wr, alu_src, mem_reg, mem_wr, mem_rd;
  logic        instr_done, illegal, bus_err;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .pc_src(pc_src), .pc_wr(pc_wr), .ir_wr(ir_wr), .iord(iord),
    .reg_wr(reg_wr), .alu_src(alu_src), .mem_reg(mem_reg), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic pc_wr, ir_wr, iord, reg_wr, alu_src, mem_reg, mem_wr, mem_rd;
    logic instr_done, illegal, bus_err;
  } obs_t;

  int n_vec = 0;
  int n_err = 0;

  bit m_ill = 0, m_bus = 0;
  int cyc, rst_at, done_at;
  bit aborted;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t base();
    obs_t o = '0;
    o.illegal = m_ill;
    o.bus_err = m_bus;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.alu_op = alu_op; o.pc_src = pc_src; o.pc_wr = pc_wr; o.ir_wr = ir_wr;
    o.iord = iord; o.reg_wr = reg_wr; o.alu_src = alu_src; o.mem_reg = mem_reg;
    o.mem_wr = mem_wr; o.mem_rd = mem_rd; o.instr_done = instr_done;
    o.illegal = illegal; o.bus_err = bus_err;
    return o;
  endfunction

  task automatic step(input logic r, input logic rdy, input obs_t e, input string tag);
    rst = r;
    mem_ready = rdy;
    @(negedge clk);
    check_val(tag, 32'(dut_obs()), 32'(e));
    if (r && instr_done && done_at < 0) done_at = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cycle(input logic rdy, input obs_t e, input string tag);
    obs_t dflt = '0;
    if (aborted) return;
    if (cyc == rst_at) begin
      step(1'b0, 1'($urandom), dflt, "rst_abort");
      m_ill = 0;
      m_bus = 0;
      aborted = 1;
    end else begin
      step(1'b1, rdy, e, tag);
    end
    cyc++;
  endtask

  // w not-ready cycles then a ready cycle; w beyond the limit means the access never answers.
  task automatic access(input int w, input obs_t e_wait, input obs_t e_done, input string tag,
                        output bit tmo);
    tmo = 0;
    for (int i = 0; i <= TO; i++) begin
      if (i == w) begin
        do_cycle(1'b1, e_done, tag);
        return;
      end
      do_cycle(1'b0, e_wait, tag);
    end
    tmo = 1;
    if (!aborted) m_bus = 1;
  endtask

  task automatic trap_seq(input int n);
    obs_t dflt = '0;
    for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), base(), "trap");
    step(1'b0, 1'($urandom), dflt, "trap_rst");
    m_ill = 0;
    m_bus = 0;
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic z, input int wf, input int wm,
                           input int ra, input int ntrap);
    obs_t e, ew;
    bit tmo;
    int exp_cyc;
    instruction = {25'($urandom), opc};
    zero = z;
    cyc = 0;
    rst_at = ra;
    aborted = 0;
    done_at = -1;

    ew = base(); ew.mem_rd = 1;
    e = ew; e.ir_wr = 1; e.pc_wr = 1;
    access(wf, ew, e, "fetch", tmo);
    if (aborted) return;
    if (tmo) begin trap_seq(ntrap); return; end

    do_cycle(1'($urandom), base(), "decode");
    if (aborted) return;

    e = base();
    case (opc)
      7'h33: e.alu_op = 2'b10;
      7'h13: begin e.alu_op = 2'b11; e.alu_src = 1; end
      7'h03, 7'h23: e.alu_src = 1;
      7'h63: begin e.alu_op = 2'b01; e.pc_src = 2'd1; e.pc_wr = z; e.instr_done = 1; end
      7'h6F: begin e.pc_src = 2'd2; e.pc_wr = 1; e.instr_done = 1; end
      default: begin m_ill = 1; trap_seq(ntrap); return; end
    endcase
    do_cycle(1'($urandom), e, "exec");
    if (aborted) return;

    if (opc == 7'h03 || opc == 7'h23) begin
      ew = base(); ew.iord = 1; ew.alu_src = 1;
      ew.mem_rd = (opc == 7'h03); ew.mem_wr = (opc == 7'h23);
      e = ew; e.instr_done = (opc == 7'h23);
      access(wm, ew, e, "mem", tmo);
      if (aborted) return;
      if (tmo) begin trap_seq(ntrap); return; end
    end

    if (opc == 7'h33 || opc == 7'h13 || opc == 7'h03) begin
      e = base(); e.reg_wr = 1; e.mem_reg = (opc == 7'h03); e.instr_done = 1;
      do_cycle(1'($urandom), e, "wb");
      if (aborted) return;
    end

    case (opc)
      7'h03:        exp_cyc = 5 + wf + wm;
      7'h23:        exp_cyc = 4 + wf + wm;
      7'h63, 7'h6F: exp_cyc = 3 + wf;
      default:      exp_cyc = 4 + wf;
    endcase
    check_val("cpi", 32'(done_at), 32'(exp_cyc));
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h63 || o == 7'h6F;
  endfunction

  function automatic int pick_wait();
    int p = $urandom_range(0, 9);
    if (p == 7) return TO;
    if (p == 8) return TO + 1;
    if (p == 9) return $urandom_range(0, TO);
    return $urandom_range(0, 2);
  endfunction

  logic [6:0] legal_ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};

  initial begin
    obs_t dflt = '0;
    logic [6:0] opc;
    cyc = 0;
    done_at = -1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, dflt, "reset0");
    step(1'b0, 1'b0, dflt, "reset1");

    run_instr(7'h33, 1'b0, 0, 0, -1, 3);
    run_instr(7'h03, 1'b0, 0, 3, -1, 3);
    run_instr(7'h63, 1'b1, 0, 0, -1, 3);
    run_instr(7'h63, 1'b0, 0, 0, -1, 3);
    run_instr(7'h23, 1'b0, 0, TO + 1, -1, 3);
    run_instr(7'h23, 1'b0, 0, TO, -1, 3);
    run_instr(7'h7F, 1'b0, 0, 0, -1, 20);
    run_instr(7'h03, 1'b0, 0, 0, 4, 3);
    run_instr(7'h6F, 1'b0, 1, 0, -1, 3);
    run_instr(7'h13, 1'b1, TO + 1, 0, -1, 2);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do opc = 7'($urandom); while (is_legal(opc));
      end else begin
        opc = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(opc, 1'($urandom), pick_wait(), pick_wait(),
                ($urandom_range(0, 14) == 0) ? $urandom_range(0, 6) : -1,
                $urandom_range(1, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
